// File: rtl/instr_fetch_pkg.sv
// Shared opcode-format, fetch-state and reset-vector constants for the fetch path
// and for the interrupt/trap logic.
package instr_fetch_pkg;

  typedef enum logic [1:0] {FMT_I, FMT_II, FMT_J, FMT_X} fmt_e;

  localparam logic [2:0]  OP_JUMP  = 3'b001;
  localparam logic [5:0]  OP_FMT2  = 6'b000100;
  localparam logic [2:0]  OP2_RETI = 3'b110;

  localparam logic [15:0] RESET_VEC = 16'hFFFE;

  localparam logic [2:0] ST_RST_VEC   = 3'd0;
  localparam logic [2:0] ST_FETCH_OP  = 3'd1;
  localparam logic [2:0] ST_FETCH_SRC = 3'd2;
  localparam logic [2:0] ST_FETCH_DST = 3'd3;
  localparam logic [2:0] ST_HOLD      = 3'd4;

  // Indexed (01, not CG3) and immediate (@PC+ == 11 on R0) take an extension word.
  function automatic logic src_ext(input logic [1:0] am, input logic [3:0] sreg);
    return (am == 2'b01 && sreg != 4'd3) || (am == 2'b11 && sreg == 4'd0);
  endfunction

endpackage

// File: rtl/ext_word_count.sv
// Opcode classifier: how many extension words follow, and whether the word is decodable.
module ext_word_count
  import instr_fetch_pkg::*;
(
  input  logic [15:0] opcode,
  output logic        need_src,
  output logic        need_dst,
  output logic        illegal
);

  fmt_e fmt;
  logic unused_bw;
  assign unused_bw = opcode[6];

  always_comb begin
    fmt      = FMT_X;
    need_src = 1'b0;
    need_dst = 1'b0;
    illegal  = 1'b0;
    if (opcode[15:14] != 2'b00)            fmt = FMT_I;
    else if (opcode[15:13] == OP_JUMP)     fmt = FMT_J;
    else if (opcode[15:10] == OP_FMT2)     fmt = FMT_II;
    case (fmt)
      FMT_I: begin
        need_src = src_ext(opcode[5:4], opcode[11:8]);
        need_dst = opcode[7];
      end
      FMT_II:  need_src = (opcode[9:7] != OP2_RETI) && src_ext(opcode[5:4], opcode[3:0]);
      FMT_J:   ;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch sequencer: owns the PC, walks opcode + extension words out of ROM and
// hands a complete bundle to the decoder under valid/ready.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_VEC_ADDR = RESET_VEC,
  parameter bit          RESET_FETCH    = 1'b1,
  parameter logic [15:0] RESET_PC       = 16'hC000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] MDB_out,
  output logic [15:0] MAB_fetch,
  output logic [15:0] reg_PC_out,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val,
  output logic [15:0] IR,
  output logic [15:0] EXT_SRC,
  output logic [15:0] EXT_DST,
  output logic [15:0] instr_pc,
  output logic [1:0]  ext_cnt,
  output logic        illegal,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam logic [2:0]  ST_INIT = RESET_FETCH ? ST_RST_VEC : ST_FETCH_OP;
  localparam logic [15:0] PC_INIT = (RESET_FETCH ? RESET_VEC_ADDR : RESET_PC) & 16'hFFFE;

  logic [2:0]  state;
  logic [15:0] pc, pc_inc, opcode;
  logic        need_src, need_dst, is_illegal;

  assign reg_PC_out = pc;
  assign pc_inc     = pc + 16'd2;
  assign MAB_fetch  = ((state == ST_RST_VEC) ? RESET_VEC_ADDR : pc) & 16'hFFFE;

  // Classify the word on the bus while fetching the opcode, the latched IR afterwards.
  assign opcode = (state == ST_FETCH_OP) ? MDB_out : IR;

  ext_word_count u_ewc (
    .opcode   (opcode),
    .need_src (need_src),
    .need_dst (need_dst),
    .illegal  (is_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      pc          <= PC_INIT;
      IR          <= '0;
      EXT_SRC     <= '0;
      EXT_DST     <= '0;
      instr_pc    <= '0;
      ext_cnt     <= '0;
      illegal     <= 1'b0;
      instr_valid <= 1'b0;
    end else if (pc_load && state != ST_RST_VEC) begin
      pc          <= pc_load_val & 16'hFFFE;
      state       <= ST_FETCH_OP;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        ST_RST_VEC: begin
          pc    <= MDB_out & 16'hFFFE;
          state <= ST_FETCH_OP;
        end
        ST_FETCH_OP: begin
          IR       <= MDB_out;
          instr_pc <= pc;
          pc       <= pc_inc;
          EXT_SRC  <= '0;
          EXT_DST  <= '0;
          ext_cnt  <= {1'b0, need_src} + {1'b0, need_dst};
          illegal  <= is_illegal;
          if (need_src)      state <= ST_FETCH_SRC;
          else if (need_dst) state <= ST_FETCH_DST;
          else begin
            state       <= ST_HOLD;
            instr_valid <= 1'b1;
          end
        end
        ST_FETCH_SRC: begin
          EXT_SRC <= MDB_out;
          pc      <= pc_inc;
          if (need_dst) state <= ST_FETCH_DST;
          else begin
            state       <= ST_HOLD;
            instr_valid <= 1'b1;
          end
        end
        ST_FETCH_DST: begin
          EXT_DST     <= MDB_out;
          pc          <= pc_inc;
          state       <= ST_HOLD;
          instr_valid <= 1'b1;
        end
        ST_HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= ST_FETCH_OP;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: instruction-level reference model checked every cycle,
// directed programs with literal expectations, then randomized ROM/ready/redirect/reset.
module tb_instr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, pc_load, instr_ready, illegal, instr_valid;
  logic [15:0] pc_load_val, MDB_out, MAB_fetch, reg_PC_out, IR, EXT_SRC, EXT_DST, instr_pc;
  logic [1:0]  ext_cnt;

  logic        rst_n_b, pc_load_b, instr_ready_b, illegal_b, instr_valid_b;
  logic [15:0] pc_load_val_b, MDB_out_b, MAB_fetch_b, reg_PC_out_b, IR_b, EXT_SRC_b, EXT_DST_b, instr_pc_b;
  logic [1:0]  ext_cnt_b;

  logic [15:0] rom  [0:32767];
  logic [15:0] rom2 [0:32767];
  assign MDB_out   = rom[MAB_fetch[15:1]];
  assign MDB_out_b = rom2[MAB_fetch_b[15:1]];

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .MDB_out(MDB_out), .MAB_fetch(MAB_fetch), .reg_PC_out(reg_PC_out),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .IR(IR), .EXT_SRC(EXT_SRC), .EXT_DST(EXT_DST),
    .instr_pc(instr_pc), .ext_cnt(ext_cnt), .illegal(illegal), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  instr_fetch #(.RESET_FETCH(1'b0), .RESET_PC(16'hFFFE)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .MDB_out(MDB_out_b), .MAB_fetch(MAB_fetch_b), .reg_PC_out(reg_PC_out_b),
    .pc_load(pc_load_b), .pc_load_val(pc_load_val_b), .IR(IR_b), .EXT_SRC(EXT_SRC_b), .EXT_DST(EXT_DST_b),
    .instr_pc(instr_pc_b), .ext_cnt(ext_cnt_b), .illegal(illegal_b), .instr_valid(instr_valid_b),
    .instr_ready(instr_ready_b)
  );

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    rom[a[15:1]] = d;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  function automatic int src_words(input logic [1:0] am, input logic [3:0] r);
    case (am)
      2'b01:   return (r == 4'd3) ? 0 : 1;
      2'b11:   return (r == 4'd0) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic classify(input logic [15:0] op, output int ns, output int nd, output bit ill);
    ns = 0; nd = 0; ill = 0;
    if (op >= 16'h4000) begin
      ns = src_words(op[5:4], op[11:8]);
      nd = op[7] ? 1 : 0;
    end else if (op >= 16'h2000) begin
      ns = 0;
    end else if (op[15:10] == 6'b000100) begin
      if (op[9:7] != 3'b110) ns = src_words(op[5:4], op[3:0]);
    end else begin
      ill = 1;
    end
  endtask

  bit          m_vec, m_valid, e_ill;
  int          m_rem, e_cnt;
  logic [15:0] m_pc, e_ir, e_src, e_dst, e_ipc;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_vec = 1; m_pc = 16'hFFFE; m_valid = 0; m_rem = 0;
    end else if (m_vec) begin
      m_pc = rom[15'h7FFF] & 16'hFFFE;
      m_vec = 0;
    end else if (pc_load) begin
      m_pc = pc_load_val & 16'hFFFE;
      m_valid = 0; m_rem = 0;
    end else if (m_valid) begin
      if (instr_ready) m_valid = 0;
    end else if (m_rem == 0) begin
      int ns, nd;
      bit ill;
      logic [15:0] a1, a2;
      e_ir = rom[m_pc[15:1]];
      classify(e_ir, ns, nd, ill);
      a1 = m_pc + 16'd2;
      a2 = ns ? m_pc + 16'd4 : a1;
      e_ipc = m_pc;
      e_ill = ill;
      e_src = ns ? rom[a1[15:1]] : 16'h0;
      e_dst = nd ? rom[a2[15:1]] : 16'h0;
      e_cnt = ns + nd;
      m_pc  = m_pc + 16'd2;
      m_rem = e_cnt;
      if (m_rem == 0) m_valid = 1;
    end else begin
      m_pc = m_pc + 16'd2;
      m_rem--;
      if (m_rem == 0) m_valid = 1;
    end
    #1;
    chk("m_mab", MAB_fetch, m_vec ? 16'hFFFE : m_pc);
    chk("m_pc", reg_PC_out, m_pc);
    chk("m_valid", {15'd0, instr_valid}, {15'd0, m_valid});
    if (m_valid) begin
      chk("m_ir", IR, e_ir);
      chk("m_src", EXT_SRC, e_src);
      chk("m_dst", EXT_DST, e_dst);
      chk("m_ipc", instr_pc, e_ipc);
      chk("m_cnt", {14'd0, ext_cnt}, e_cnt[15:0]);
      chk("m_ill", {15'd0, illegal}, {15'd0, e_ill});
    end
  end

  task automatic reset_dut();
    rst_n = 0; pc_load = 0; pc_load_val = '0; instr_ready = 1;
    tick(); tick();
    for (int i = 0; i < 32768; i++) rom[i] = 16'h0;
    wr(16'hFFFE, 16'hC000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0; pc_load = 0; pc_load_val = '0; instr_ready = 1;
    rst_n_b = 0; pc_load_b = 0; pc_load_val_b = '0; instr_ready_b = 0;
    for (int i = 0; i < 32768; i++) begin rom[i] = 16'h0; rom2[i] = 16'h0; end

    // MOV #1,R5 via constant generator: no extension
    reset_dut();
    wr(16'hC000, 16'h4315);
    rst_n = 1;
    chk("t1_mab_vec", MAB_fetch, 16'hFFFE);
    tick();
    chk("t1_mab_op", MAB_fetch, 16'hC000);
    chk("t1_valid0", {15'd0, instr_valid}, 16'd0);
    tick();
    chk("t1_valid", {15'd0, instr_valid}, 16'd1);
    chk("t1_ir", IR, 16'h4315);
    chk("t1_cnt", {14'd0, ext_cnt}, 16'd0);
    chk("t1_ipc", instr_pc, 16'hC000);
    chk("t1_pc", reg_PC_out, 16'hC002);

    // MOV #1234h,R5: immediate source
    reset_dut();
    wr(16'hC000, 16'h4035); wr(16'hC002, 16'h1234);
    rst_n = 1;
    tick(); tick();
    chk("t2_valid0", {15'd0, instr_valid}, 16'd0);
    tick();
    chk("t2_valid", {15'd0, instr_valid}, 16'd1);
    chk("t2_src", EXT_SRC, 16'h1234);
    chk("t2_dst", EXT_DST, 16'h0000);
    chk("t2_cnt", {14'd0, ext_cnt}, 16'd1);
    chk("t2_pc", reg_PC_out, 16'hC004);

    // ADD 2(R4),6(R5): two extension words
    reset_dut();
    wr(16'hC000, 16'h5495); wr(16'hC002, 16'h0002); wr(16'hC004, 16'h0006);
    rst_n = 1;
    tick(); tick(); tick();
    chk("t3_valid0", {15'd0, instr_valid}, 16'd0);
    tick();
    chk("t3_valid", {15'd0, instr_valid}, 16'd1);
    chk("t3_src", EXT_SRC, 16'h0002);
    chk("t3_dst", EXT_DST, 16'h0006);
    chk("t3_cnt", {14'd0, ext_cnt}, 16'd2);
    chk("t3_pc", reg_PC_out, 16'hC006);

    // Decoder stall on JMP
    reset_dut();
    wr(16'hC000, 16'h3C00);
    instr_ready = 0;
    rst_n = 1;
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      chk("t4_valid", {15'd0, instr_valid}, 16'd1);
      chk("t4_ir", IR, 16'h3C00);
      chk("t4_pc", reg_PC_out, 16'hC002);
      if (k < 4) tick();
    end
    instr_ready = 1;
    tick();
    chk("t4_mab", MAB_fetch, 16'hC002);
    chk("t4_valid0", {15'd0, instr_valid}, 16'd0);

    // Redirect while the source extension is being fetched
    reset_dut();
    wr(16'hC000, 16'h4035); wr(16'hC002, 16'hBEEF); wr(16'hE000, 16'h4315);
    rst_n = 1;
    tick(); tick();
    pc_load = 1; pc_load_val = 16'hE001;
    tick();
    pc_load = 0;
    chk("t5_valid0", {15'd0, instr_valid}, 16'd0);
    chk("t5_mab", MAB_fetch, 16'hE000);
    chk("t5_pc", reg_PC_out, 16'hE000);
    tick();
    chk("t5_valid", {15'd0, instr_valid}, 16'd1);
    chk("t5_ipc", instr_pc, 16'hE000);
    chk("t5_ir", IR, 16'h4315);

    // Randomized ROM, handshake, redirects and resets
    reset_dut();
    for (int i = 0; i < 32768; i++) rom[i] = 16'($urandom);
    wr(16'hFFFE, 16'hC000);
    rst_n = 1;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 299) == 0) rst_n = 0;
      instr_ready = ($urandom_range(0, 3) != 0);
      pc_load     = ($urandom_range(0, 19) == 0);
      pc_load_val = 16'($urandom);
    end
    pc_load = 0;

    // No reset-vector fetch, PC wraps past FFFE; reset drops a held bundle at once
    rom2[15'h7FFF] = 16'h4315;
    tick();
    rst_n_b = 1;
    chk("t6_mab", MAB_fetch_b, 16'hFFFE);
    chk("t6_pc0", reg_PC_out_b, 16'hFFFE);
    tick();
    chk("t6_valid", {15'd0, instr_valid_b}, 16'd1);
    chk("t6_ir", IR_b, 16'h4315);
    chk("t6_ipc", instr_pc_b, 16'hFFFE);
    chk("t6_pc", reg_PC_out_b, 16'h0000);
    chk("t6_cnt", {14'd0, ext_cnt_b}, 16'd0);
    tick();
    chk("t6_hold", {15'd0, instr_valid_b}, 16'd1);
    rst_n_b = 0;
    #1;
    chk("t6_rst_valid", {15'd0, instr_valid_b}, 16'd0);
    chk("t6_rst_pc", reg_PC_out_b, 16'hFFFE);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
